// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one ALU between two requesters (slot 0: execute stage, slot 1:
//   debug/test port), one operation in flight at a time. A request is taken
//   over a valid/ready handshake and its fields are registered onto the ALU
//   inputs. The arbiter then waits ALU_LAT cycles and captures the result and
//   flags into a valid/ready response channel. Each slot owns a private
//   carry/zero context, so carry chains from one slot never see the other's
//   flags.
//
// Parameters
//   OP_W, SH_W     opcode / shift-op field widths
//   OPERAND_WIDTH  operand and result width
//   ALU_LAT        ALU pipeline depth in cycles (0 = combinational ALU)
//
// Ports
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready [1:0]     per-slot request handshake
//   req_op, req_shift_op, req_shift_dir, req_shift_const,
//   req_use_carry, req_flag_we, req_a, req_b   per-slot request fields
//   alu_*  (out)                  registered ALU inputs
//   alu_result, alu_zero_out, alu_carry_out    ALU outputs
//   rsp_valid/rsp_ready           response handshake
//   rsp_id, rsp_result, rsp_zero, rsp_carry    captured response
//   flag_zero, flag_carry [1:0]   per-slot stored flag context
//
// Configuration macro
//   ALU_ARB_FIXED_PRIO_EN  defined: slot 0 always wins a tie, no pointer.
//                          undefined: round robin between the two slots.

module alu_arbiter #(
  parameter int OP_W          = 5,
  parameter int SH_W          = 3,
  parameter int OPERAND_WIDTH = 8,
  parameter int ALU_LAT       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*OP_W-1:0]          req_op,
  input  logic [2*SH_W-1:0]          req_shift_op,
  input  logic [1:0]                 req_shift_dir,
  input  logic [1:0]                 req_shift_const,
  input  logic [1:0]                 req_use_carry,
  input  logic [1:0]                 req_flag_we,
  input  logic [2*OPERAND_WIDTH-1:0] req_a,
  input  logic [2*OPERAND_WIDTH-1:0] req_b,
  output logic [OP_W-1:0]            alu_op,
  output logic [SH_W-1:0]            alu_shift_op,
  output logic                       alu_shift_dir,
  output logic                       alu_shift_const,
  output logic                       alu_carry_in,
  output logic [OPERAND_WIDTH-1:0]   alu_operand_a,
  output logic [OPERAND_WIDTH-1:0]   alu_operand_b,
  input  logic [OPERAND_WIDTH-1:0]   alu_result,
  input  logic                       alu_zero_out,
  input  logic                       alu_carry_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [OPERAND_WIDTH-1:0]   rsp_result,
  output logic                       rsp_zero,
  output logic                       rsp_carry,
  output logic [1:0]                 flag_zero,
  output logic [1:0]                 flag_carry
);

  localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant;
  logic               accept;
  logic               capture;

  logic [OP_W-1:0]          alu_op_q;
  logic [SH_W-1:0]          alu_shift_op_q;
  logic                     alu_shift_dir_q;
  logic                     alu_shift_const_q;
  logic                     alu_carry_in_q;
  logic [OPERAND_WIDTH-1:0] alu_a_q;
  logic [OPERAND_WIDTH-1:0] alu_b_q;
  logic                     owner_q;
  logic                     flag_we_q;
  logic                     rsp_id_q;
  logic [OPERAND_WIDTH-1:0] rsp_result_q;
  logic                     rsp_zero_q;
  logic                     rsp_carry_q;
  logic [1:0]               flag_zero_q;
  logic [1:0]               flag_carry_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Slot that wins the next tie; flips away from whoever was just granted.
  logic prio_q;
`endif

  // Tie-break: with a single valid slot the grant simply follows it.
  always_comb begin
    if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = prio_q;
`endif
    end else begin
      grant = ~req_valid[0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    capture   = 1'b0;
    req_ready = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          cnt_d            = CNT_W'(ALU_LAT);
          state_d          = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (accept) begin
      prio_q <= ~grant;
    end
  end
`endif

  // Accept stage: latch the granted slot's fields onto the ALU inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_q          <= '0;
      alu_shift_op_q    <= '0;
      alu_shift_dir_q   <= 1'b0;
      alu_shift_const_q <= 1'b0;
      alu_carry_in_q    <= 1'b0;
      alu_a_q           <= '0;
      alu_b_q           <= '0;
      owner_q           <= 1'b0;
      flag_we_q         <= 1'b0;
    end else if (accept) begin
      alu_op_q          <= grant ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
      alu_shift_op_q    <= grant ? req_shift_op[2*SH_W-1:SH_W] : req_shift_op[SH_W-1:0];
      alu_shift_dir_q   <= req_shift_dir[grant];
      alu_shift_const_q <= req_shift_const[grant];
      // Carry-in comes from the granting slot's own context only.
      alu_carry_in_q    <= req_use_carry[grant] & flag_carry_q[grant];
      alu_a_q           <= grant ? req_a[2*OPERAND_WIDTH-1:OPERAND_WIDTH] : req_a[OPERAND_WIDTH-1:0];
      alu_b_q           <= grant ? req_b[2*OPERAND_WIDTH-1:OPERAND_WIDTH] : req_b[OPERAND_WIDTH-1:0];
      owner_q           <= grant;
      flag_we_q         <= req_flag_we[grant];
    end
  end

  // Capture stage: ALU output into the response registers and owner's flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      flag_zero_q  <= 2'b00;
      flag_carry_q <= 2'b00;
    end else if (capture) begin
      rsp_id_q     <= owner_q;
      rsp_result_q <= alu_result;
      rsp_zero_q   <= alu_zero_out;
      rsp_carry_q  <= alu_carry_out;
      if (flag_we_q) begin
        flag_zero_q[owner_q]  <= alu_zero_out;
        flag_carry_q[owner_q] <= alu_carry_out;
      end
    end
  end

  assign alu_op          = alu_op_q;
  assign alu_shift_op    = alu_shift_op_q;
  assign alu_shift_dir   = alu_shift_dir_q;
  assign alu_shift_const = alu_shift_const_q;
  assign alu_carry_in    = alu_carry_in_q;
  assign alu_operand_a   = alu_a_q;
  assign alu_operand_b   = alu_b_q;
  assign rsp_valid       = (state_q == RESP);
  assign rsp_id          = rsp_id_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_zero        = rsp_zero_q;
  assign rsp_carry       = rsp_carry_q;
  assign flag_zero       = flag_zero_q;
  assign flag_carry      = flag_carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int LAT = 2;
  localparam logic [4:0] OP_ADD   = 5'd12;
  localparam logic [4:0] OP_ADDCY = 5'd13;
  localparam logic [4:0] OP_SUB   = 5'd14;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_op;
  logic [5:0]  req_shift_op;
  logic [1:0]  req_shift_dir;
  logic [1:0]  req_shift_const;
  logic [1:0]  req_use_carry;
  logic [1:0]  req_flag_we;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [4:0]  alu_op;
  logic [2:0]  alu_shift_op;
  logic        alu_shift_dir;
  logic        alu_shift_const;
  logic        alu_carry_in;
  logic [7:0]  alu_operand_a;
  logic [7:0]  alu_operand_b;
  logic [7:0]  alu_result;
  logic        alu_zero_out;
  logic        alu_carry_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic [1:0]  flag_zero;
  logic [1:0]  flag_carry;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .OP_W(5), .SH_W(3), .OPERAND_WIDTH(8), .ALU_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_shift_op(req_shift_op),
    .req_shift_dir(req_shift_dir), .req_shift_const(req_shift_const),
    .req_use_carry(req_use_carry), .req_flag_we(req_flag_we),
    .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_shift_op(alu_shift_op),
    .alu_shift_dir(alu_shift_dir), .alu_shift_const(alu_shift_const),
    .alu_carry_in(alu_carry_in),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_zero_out(alu_zero_out),
    .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .flag_zero(flag_zero), .flag_carry(flag_carry)
  );

  // Small ALU model: inputs are held by the arbiter for the whole EXEC phase.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'd0;
    case (alu_op)
      OP_ADD:   alu_sum = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
      OP_ADDCY: alu_sum = {1'b0, alu_operand_a} + {1'b0, alu_operand_b} + {8'd0, alu_carry_in};
      OP_SUB:   alu_sum = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
      default:  alu_sum = 9'd0;
    endcase
  end
  assign alu_result    = alu_sum[7:0];
  assign alu_carry_out = alu_sum[8];
  assign alu_zero_out  = (alu_sum[7:0] == 8'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int s, input logic [4:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic uc, input logic fwe);
    req_op[s*5 +: 5] = op;
    req_shift_op[s*3 +: 3] = 3'd0;
    req_shift_dir[s] = 1'b0;
    req_shift_const[s] = 1'b0;
    req_use_carry[s] = uc;
    req_flag_we[s] = fwe;
    req_a[s*8 +: 8] = a;
    req_b[s*8 +: 8] = b;
  endtask

  // Bounded wait for rsp_valid; n is the number of edges it took.
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  // One isolated operation with rsp_ready held high.
  task automatic single_op(input string tag, input int s, input logic [4:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic uc, input logic fwe,
                           input logic [7:0] er, input logic ez, input logic ec);
    int n;
    set_req(s, op, a, b, uc, fwe);
    req_valid = (s == 0) ? 2'b01 : 2'b10;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(req_valid));
    tick();
    req_valid = 2'b00;
    wait_rsp(n);
    check({tag, "_lat"}, n, LAT + 1);
    check({tag, "_id"}, 32'(rsp_id), s);
    check({tag, "_res"}, 32'(rsp_result), 32'(er));
    check({tag, "_z"}, 32'(rsp_zero), 32'(ez));
    check({tag, "_c"}, 32'(rsp_carry), 32'(ec));
    tick();
  endtask

  initial begin
    int n;
    logic seen;
    logic exp_id;
    rst = 1'b1;
    req_valid = 2'b00;
    req_op = '0; req_shift_op = '0; req_shift_dir = '0; req_shift_const = '0;
    req_use_carry = '0; req_flag_we = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_result", 32'(rsp_result), 0);
    check("rst_flags", {28'd0, flag_zero, flag_carry}, 0);
    check("rst_alu_a", 32'(alu_operand_a), 0);
    rst = 1'b0;
    tick();

    // Carry chain within slot 0, then the same op from slot 1.
    single_op("add0", 0, OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    check("add0_fc", 32'(flag_carry), 32'h1);
    check("add0_fz", 32'(flag_zero), 32'h1);
    single_op("adc0", 0, OP_ADDCY, 8'h01, 8'h01, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    check("adc0_fc", 32'(flag_carry), 32'h0);
    single_op("adc1", 1, OP_ADDCY, 8'h01, 8'h01, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    single_op("nowe1", 1, OP_ADD, 8'hFF, 8'h02, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
    check("nowe1_fc", 32'(flag_carry), 32'h0);

    // Both slots held valid: grant order and throughput.
    set_req(0, OP_ADD, 8'h10, 8'h01, 1'b0, 1'b0);
    set_req(1, OP_ADD, 8'h20, 8'h02, 1'b0, 1'b0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(n);
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = k[0];
`endif
      check($sformatf("rr%0d_gap", k), n, LAT + 2);
      check($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(exp_id));
      check($sformatf("rr%0d_res", k), 32'(rsp_result), exp_id ? 32'h22 : 32'h11);
      tick();
    end
    req_valid = 2'b00;
    tick();

    // Response back-pressure with slot 1 waiting.
    rsp_ready = 1'b0;
    set_req(0, OP_SUB, 8'h30, 8'h05, 1'b0, 1'b0);
    req_valid = 2'b01;
    #1;
    tick();
    set_req(1, OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b1);
    req_valid = 2'b10;
    wait_rsp(n);
    check("bp_lat", n, LAT + 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), 32'(rsp_valid), 1);
      check($sformatf("bp%0d_res", i), 32'(rsp_result), 32'h2B);
      check($sformatf("bp%0d_ready", i), 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_after_ready", 32'(req_ready), 32'h2);
    tick();
    check("bp_exec_ready", 32'(req_ready), 0);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    wait_rsp(n);
    check("bp1_lat", n, LAT + 1);
    check("bp1_id", 32'(rsp_id), 1);
    check("bp1_res", 32'(rsp_result), 32'h00);
    tick();
    check("bp1_fc", 32'(flag_carry), 32'h2);
    check("bp1_fz", 32'(flag_zero), 32'h2);

    // Reset two cycles into EXEC; slot 0 was granted last before reset.
    set_req(0, OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b1);
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rr_rst_valid", 32'(rsp_valid), 0);
    check("rr_rst_flags", {28'd0, flag_zero, flag_carry}, 0);
    check("rr_rst_alu_a", 32'(alu_operand_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | rsp_valid;
      tick();
    end
    check("rr_rst_no_rsp", 32'(seen), 0);
    set_req(1, OP_ADD, 8'h01, 8'h01, 1'b0, 1'b0);
    req_valid = 2'b11;
    #1;
    check("rr_rst_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    wait_rsp(n);
    check("rr_rst_id", 32'(rsp_id), 0);
    check("rr_rst_res", 32'(rsp_result), 32'h00);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
